// File: rtl/spi_byte_port.sv
// spi_byte_port: SPI mode-0 target front end for the FDC SRAM arbiter.
// Oversamples the host SPI pins in clock_50. Each received byte is delivered
// as a one-cycle strobe. Each transmit byte is taken from a holding register
// that the arbiter fills through send_latch.
//
// Ports
//   clock_50            system clock
//   reset               asynchronous active-low reset
//   sclk, mosi, ss      raw host SPI pins (mode 0, MSB first, ss active low)
//   miso                SPI data to host, high-Z outside a frame
//   byte_received       one-cycle pulse, byte_data_received newly valid
//   byte_data_received  last complete received byte
//   byte_send           byte to transmit
//   send_latch          level; captures byte_send as the pending TX byte
//   frame_active        synchronised, inverted ss
//   tx_underrun         sticky; FILL_BYTE was sent, cleared on ss falling edge
module spi_byte_port #(
    parameter logic [7:0]  FILL_BYTE   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       ss,
    output logic       miso,
    output logic       byte_received,
    output logic [7:0] byte_data_received,
    input  logic [7:0] byte_send,
    input  logic       send_latch,
    output logic       frame_active,
    output logic       tx_underrun
);

    localparam int unsigned MOSI_STAGES = SYNC_STAGES - 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [MOSI_STAGES-1:0] mosi_sync;

    logic sck_rise_c;
    logic sck_fall_c;
    logic ss_fall_c;
    logic ss_rise_c;
    logic mosi_s_c;

    state_t     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] hold_q, hold_d;
    logic       pending_q, pending_d;
    logic       byte_seen_q, byte_seen_d;
    logic       done_q, done_d;
    logic       byte_received_d;
    logic [7:0] byte_data_d;
    logic       frame_active_d;
    logic       tx_underrun_d;

    logic [7:0] load_val_c;
    logic       load_fill_c;

    // Pin synchronisers; MOSI is one stage shorter so its last stage lines up
    // with the sclk edge detected on the two oldest sclk stages.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[MOSI_STAGES-2:0], mosi};
        end
    end

    assign sck_rise_c = sck_sync[SYNC_STAGES-2] & ~sck_sync[SYNC_STAGES-1];
    assign sck_fall_c = ~sck_sync[SYNC_STAGES-2] & sck_sync[SYNC_STAGES-1];
    assign ss_fall_c  = ~ss_sync[SYNC_STAGES-2] & ss_sync[SYNC_STAGES-1];
    assign ss_rise_c  = ss_sync[SYNC_STAGES-2] & ~ss_sync[SYNC_STAGES-1];
    assign mosi_s_c   = mosi_sync[MOSI_STAGES-1];

    // Byte-boundary source: live latch bypass, then held byte, then fill.
    always_comb begin
        load_fill_c = 1'b0;
        if (send_latch) begin
            load_val_c = byte_send;
        end else if (pending_q) begin
            load_val_c = hold_q;
        end else begin
            load_val_c  = FILL_BYTE;
            load_fill_c = 1'b1;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d         = state_q;
        bitcnt_d        = bitcnt_q;
        rx_shift_d      = rx_shift_q;
        tx_shift_d      = tx_shift_q;
        hold_d          = hold_q;
        pending_d       = pending_q;
        byte_seen_d     = byte_seen_q;
        done_d          = 1'b0;
        byte_received_d = 1'b0;
        byte_data_d     = byte_data_received;
        tx_underrun_d   = tx_underrun;

        // Completion is flagged on the 8th rise and published one cycle later,
        // independent of state so an ss rise on that rise still delivers it.
        if (done_q) begin
            byte_data_d     = rx_shift_q;
            byte_received_d = 1'b1;
        end

        if (send_latch) begin
            hold_d    = byte_send;
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (ss_fall_c) begin
                    bitcnt_d    = 3'd0;
                    rx_shift_d  = 8'h00;
                    tx_shift_d  = load_val_c;
                    pending_d   = 1'b0;
                    byte_seen_d = 1'b0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (sck_rise_c) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_s_c};
                    bitcnt_d   = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        done_d      = 1'b1;
                        byte_seen_d = 1'b1;
                    end
                end else if (sck_fall_c) begin
                    if (bitcnt_q != 3'd0) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end else if (byte_seen_q) begin
                        tx_shift_d = load_val_c;
                        pending_d  = 1'b0;
                        if (load_fill_c) begin
                            tx_underrun_d = 1'b1;
                        end
                    end
                end
                if (ss_rise_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The frame-start clear wins over any set, so the ss_fall load never flags.
        if (ss_fall_c) begin
            tx_underrun_d = 1'b0;
        end

        frame_active_d = (state_d == SHIFT);
    end

    // State register.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            state_q            <= IDLE;
            bitcnt_q           <= 3'd0;
            rx_shift_q         <= 8'h00;
            tx_shift_q         <= FILL_BYTE;
            hold_q             <= 8'h00;
            pending_q          <= 1'b0;
            byte_seen_q        <= 1'b0;
            done_q             <= 1'b0;
            byte_received      <= 1'b0;
            byte_data_received <= 8'h00;
            frame_active       <= 1'b0;
            tx_underrun        <= 1'b0;
        end else begin
            state_q            <= state_d;
            bitcnt_q           <= bitcnt_d;
            rx_shift_q         <= rx_shift_d;
            tx_shift_q         <= tx_shift_d;
            hold_q             <= hold_d;
            pending_q          <= pending_d;
            byte_seen_q        <= byte_seen_d;
            done_q             <= done_d;
            byte_received      <= byte_received_d;
            byte_data_received <= byte_data_d;
            frame_active       <= frame_active_d;
            tx_underrun        <= tx_underrun_d;
        end
    end

    // MISO is driven only inside a frame.
    assign miso = frame_active ? tx_shift_q[7] : 1'bz;

endmodule

// File: tb/tb_spi_byte_port.sv
// Directed testbench for spi_byte_port: the host SPI master is bit-banged
// from the stimulus block and each result is checked with an immediate assertion.
module tb_spi_byte_port;

    logic       clock_50 = 1'b0;
    logic       reset;
    logic       sclk;
    logic       mosi;
    logic       ss;
    wire        miso;
    logic       byte_received;
    logic [7:0] byte_data_received;
    logic [7:0] byte_send;
    logic       send_latch;
    logic       frame_active;
    logic       tx_underrun;

    // Pull the line low so an undriven MISO reads 0 (idle tx shift holds 1s).
    pulldown pd_miso (miso);

    int n_asserts = 0;
    int n_fails   = 0;
    int rx_count  = 0;
    logic [7:0] rx_log [0:15];
    bit   found;
    logic [7:0] seen0, seen1, seen2, seen3;

    spi_byte_port dut (
        .clock_50           (clock_50),
        .reset              (reset),
        .sclk               (sclk),
        .mosi               (mosi),
        .ss                 (ss),
        .miso               (miso),
        .byte_received      (byte_received),
        .byte_data_received (byte_data_received),
        .byte_send          (byte_send),
        .send_latch         (send_latch),
        .frame_active       (frame_active),
        .tx_underrun        (tx_underrun)
    );

    always #10 clock_50 = ~clock_50;

    // Log every delivered byte.
    always @(posedge clock_50) begin
        if (byte_received === 1'b1) begin
            if (rx_count < 16) rx_log[rx_count] <= byte_data_received;
            rx_count <= rx_count + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, required end before 1 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs == exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Host master, mode 0, 240 ns SCK period. MISO is sampled just before each rise.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] seen);
        seen = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            mosi = tx[3'(i)];
            #120;
            seen[3'(i)] = miso;
            sclk = 1'b1;
            #120;
            sclk = 1'b0;
        end
    endtask

    initial begin
        reset      = 1'b0;
        sclk       = 1'b0;
        mosi       = 1'b0;
        ss         = 1'b1;
        send_latch = 1'b0;
        byte_send  = 8'h00;

        // Reset state
        repeat (3) @(negedge clock_50);
        check1("rst_pulse", byte_received, 1'b0);
        check8("rst_data", byte_data_received, 8'h00);
        check1("rst_frame", frame_active, 1'b0);
        check1("rst_underrun", tx_underrun, 1'b0);
        check1("rst_miso_hiz", miso, 1'b0);
        reset = 1'b1;
        repeat (5) @(negedge clock_50);

        // Single byte A5 with fill on MISO; pulse latency and width
        ss = 1'b0;
        fork
            spi_xfer(8'hA5, 8, seen0);
            begin
                repeat (8) @(posedge sclk);
                repeat (3) @(posedge clock_50);
                #1 check1("t1_lat_early", byte_received, 1'b0);
                @(posedge clock_50);
                #1 check1("t1_lat_pulse", byte_received, 1'b1);
                check1("t1_underrun", tx_underrun, 1'b0);
                check1("t1_frame", frame_active, 1'b1);
                @(posedge clock_50);
                #1 check1("t1_pulse_width", byte_received, 1'b0);
            end
        join
        repeat (6) @(negedge clock_50);
        check8("t1_miso", seen0, 8'hFF);
        check8("t1_data", byte_data_received, 8'hA5);
        checkn("t1_count", rx_count, 1);
        ss = 1'b1;
        repeat (8) @(negedge clock_50);
        check1("t1_frame_end", frame_active, 1'b0);
        check1("t1_miso_hiz", miso, 1'b0);

        // Reset mid-frame with 5 bits of 5A clocked in
        @(negedge clock_50);
        ss = 1'b0;
        spi_xfer(8'h5A, 5, seen0);
        @(negedge clock_50);
        reset = 1'b0;
        #1;
        check8("t2_data", byte_data_received, 8'h00);
        check1("t2_pulse", byte_received, 1'b0);
        check1("t2_frame", frame_active, 1'b0);
        check1("t2_underrun", tx_underrun, 1'b0);
        check1("t2_miso_hiz", miso, 1'b0);
        ss = 1'b1;
        repeat (4) @(negedge clock_50);
        reset = 1'b1;
        repeat (20) @(negedge clock_50);
        checkn("t2_count", rx_count, 1);
        check1("t2_frame_after", frame_active, 1'b0);

        // Arbiter answers the first byte through a one-cycle send_latch
        ss = 1'b0;
        fork
            spi_xfer(8'h03, 8, seen0);
            begin
                found = 1'b0;
                for (int k = 0; k < 400 && !found; k++) begin
                    @(negedge clock_50);
                    if (byte_received === 1'b1) found = 1'b1;
                end
                check1("t3_wait_pulse", found, 1'b1);
                if (found) begin
                    @(negedge clock_50);
                    byte_send  = 8'h3C;
                    send_latch = 1'b1;
                    @(negedge clock_50);
                    send_latch = 1'b0;
                    byte_send  = 8'h00;
                end
            end
        join
        repeat (6) @(negedge clock_50);
        check8("t3_miso1", seen0, 8'hFF);
        check8("t3_data1", byte_data_received, 8'h03);
        check1("t3_underrun", tx_underrun, 1'b0);
        spi_xfer(8'h00, 8, seen1);
        repeat (6) @(negedge clock_50);
        check8("t3_miso2", seen1, 8'h3C);
        check8("t3_data2", byte_data_received, 8'h00);
        checkn("t3_count", rx_count, 3);
        ss = 1'b1;
        repeat (8) @(negedge clock_50);

        // Three bytes without send_latch: underrun, sticky, cleared at next frame
        ss = 1'b0;
        spi_xfer(8'h11, 8, seen0);
        repeat (6) @(negedge clock_50);
        check1("t4_underrun_set", tx_underrun, 1'b1);
        spi_xfer(8'h22, 8, seen1);
        spi_xfer(8'h33, 8, seen2);
        repeat (6) @(negedge clock_50);
        check8("t4_miso1", seen0, 8'hFF);
        check8("t4_miso2", seen1, 8'hFF);
        check8("t4_miso3", seen2, 8'hFF);
        check8("t4_data", byte_data_received, 8'h33);
        checkn("t4_count", rx_count, 6);
        ss = 1'b1;
        repeat (8) @(negedge clock_50);
        check1("t4_underrun_sticky", tx_underrun, 1'b1);
        ss = 1'b0;
        repeat (8) @(negedge clock_50);
        check1("t4_underrun_clear", tx_underrun, 1'b0);
        ss = 1'b1;
        repeat (8) @(negedge clock_50);

        // Abort after 5 bits of C3, then a full 81 frame
        ss = 1'b0;
        spi_xfer(8'hC3, 5, seen0);
        repeat (4) @(negedge clock_50);
        ss = 1'b1;
        repeat (20) @(negedge clock_50);
        checkn("t5_count_abort", rx_count, 6);
        check8("t5_data_hold", byte_data_received, 8'h33);
        ss = 1'b0;
        spi_xfer(8'h81, 8, seen0);
        repeat (6) @(negedge clock_50);
        check8("t5_data", byte_data_received, 8'h81);
        checkn("t5_count", rx_count, 7);
        ss = 1'b1;
        repeat (8) @(negedge clock_50);

        // send_latch held high with 77 across four bytes
        byte_send  = 8'h77;
        send_latch = 1'b1;
        @(negedge clock_50);
        ss = 1'b0;
        spi_xfer(8'hA1, 8, seen0);
        spi_xfer(8'hB2, 8, seen1);
        spi_xfer(8'hC3, 8, seen2);
        spi_xfer(8'hD4, 8, seen3);
        repeat (6) @(negedge clock_50);
        check8("t6_miso1", seen0, 8'h77);
        check8("t6_miso2", seen1, 8'h77);
        check8("t6_miso3", seen2, 8'h77);
        check8("t6_miso4", seen3, 8'h77);
        checkn("t6_count", rx_count, 11);
        check8("t6_rx1", rx_log[7], 8'hA1);
        check8("t6_rx2", rx_log[8], 8'hB2);
        check8("t6_rx3", rx_log[9], 8'hC3);
        check8("t6_rx4", rx_log[10], 8'hD4);
        check1("t6_underrun", tx_underrun, 1'b0);
        send_latch = 1'b0;
        ss = 1'b1;
        repeat (8) @(negedge clock_50);

        // Earlier delivered bytes
        check8("log_a5", rx_log[0], 8'hA5);
        check8("log_03", rx_log[1], 8'h03);
        check8("log_00", rx_log[2], 8'h00);
        check8("log_81", rx_log[6], 8'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/spi_byte_port.md
Name: spi_byte_port

Overview:
- SPI mode-0 target front end that turns the raw host SPI pins into byte-wide strobes for the FDC SRAM arbiter.
- Receive side: delivers each received byte as a one-cycle byte_received pulse with byte_data_received.
- Transmit side: accepts the arbiter's read byte via byte_send/send_latch and shifts it out on MISO in the next byte slot.
- All pins are synchronised into clock_50; nothing in the block runs on SCK.

Parameters:
FILL_BYTE, 8'hFF, byte shifted out when no transmit byte is pending at a byte boundary
SYNC_STAGES, 3, flops in the SCK/SS synchroniser chain (min 3; MOSI uses SYNC_STAGES-1)

Ports:
clock_50  input  1  system clock, 50 MHz
reset  input  1  asynchronous active-low reset
sclk  input  1  SPI clock from host, idle low (mode 0)
mosi  input  1  SPI data from host, MSB first
ss  input  1  SPI select, active low
miso  output  1  SPI data to host; high-Z while ss high
byte_received  output  1  one-cycle pulse: byte_data_received newly valid
byte_data_received  output  8  last complete received byte
byte_send  input  8  byte to transmit
send_latch  input  1  level; while high, byte_send is captured as pending TX byte
frame_active  output  1  synchronised, inverted ss
tx_underrun  output  1  sticky; FILL_BYTE was sent; cleared on ss falling edge

Behaviour:
- Reset (async, reset low) clears all state:
  - byte_received=0, byte_data_received=8'h00, frame_active=0, tx_underrun=0.
  - miso high-Z; bit counter=0; rx shift=0; tx shift=FILL_BYTE; tx pending=0; synchronisers=idle (sclk 0, ss 1).
- Synchronise sclk and ss through SYNC_STAGES flops. Edges are detected on the two oldest stages:
  - sck_rise: 0 to 1; sck_fall: 1 to 0.
  - ss_fall: 1 to 0; ss_rise: 0 to 1.
  - mosi is sampled from its last stage, so it is aligned with the sck_rise detection.
- TX holding register:
  - Every cycle send_latch=1: holding <= byte_send, pending <= 1.
  - A held-high send_latch therefore re-arms continuously with the same byte. This is legal.
- Byte-boundary load occurs on the ss_fall cycle, and on the sck_fall cycle that follows the 8th sck_rise of a byte:
  - If send_latch=1 in that cycle, load byte_send directly (bypass) and clear pending.
  - Else if pending=1, load holding and clear pending.
  - Else load FILL_BYTE and set tx_underrun. Exception: the very first load after ss_fall does not set tx_underrun.
- On ss_fall, tx_underrun is cleared, and the clear takes precedence over any set in the same cycle.
- State machine:
  - IDLE:
    - frame_active=0; miso=Z; sck edges ignored.
    - ss_fall: bitcnt=0, perform boundary load, go SHIFT.
  - SHIFT:
    - frame_active=1; miso = tx_shift[7].
    - sck_rise: rx_shift <= {rx_shift[6:0], mosi_s}; bitcnt++.
    - When bitcnt was 7 at the sck_rise: in the next cycle byte_data_received <= completed byte, byte_received=1 for exactly one cycle, and bitcnt wraps to 0.
    - sck_fall: if bitcnt != 0, tx_shift <= tx_shift<<1; if bitcnt == 0 and at least one byte is complete in the frame, perform boundary load.
    - ss_rise: go IDLE.
- Latency: byte_received is high SYNC_STAGES+1 clock_50 cycles after the 8th SCK rising edge at the pin.
- byte_data_received holds its value until the next complete byte.
- ss_rise mid-byte: the partial byte is discarded, no byte_received pulse, and bitcnt resets on the next ss_fall.
- ss_rise in the same cycle as the 8th sck_rise: the byte still completes and pulses.
- sck_rise and sck_fall in the same cycle cannot occur; synchroniser glitches are not filtered beyond synchronisation.
- Throughput:
  - SCK up to clock_50/8 (6.25 MHz).
  - The host must leave at least 4 clock_50 cycles between the 8th SCK fall and the next byte, so that send_latch driven from the byte_received response is picked up.

Test Plan:
- Reset low mid-frame with rx shift=8'h5A partially clocked -> all outputs return to reset values immediately; miso=Z; no byte_received after release.
- ss low, host sends 8'hA5 at 4 MHz -> exactly one byte_received pulse, byte_data_received=8'hA5; miso carries 8'hFF (FILL); tx_underrun stays 0.
- Host sends bytes 8'h03, 8'h00; bench pulses send_latch with byte_send=8'h3C one cycle after the first byte_received -> miso shows 8'h3C during the second byte; tx_underrun=0.
- Three bytes with no send_latch -> bytes 2 and 3 shift 8'hFF; tx_underrun=1 after the first boundary; next ss_fall clears it to 0.
- ss raised after 5 bits of 8'hC3 -> no pulse; byte_data_received keeps its prior value; next full frame 8'h81 is received correctly.
- send_latch held high with byte_send=8'h77 across 4 bytes -> miso shows 8'h77 each byte; byte_received pulses 4 times with the MOSI values.
